pma_check_pipe: RTL

- Pipelined physical-memory-attribute (PMA) checker between the MMU/PTW output and the fetch and LSU consumers.
- Takes a physical address, access type and tag per request.
- Classifies the address against the configured execute, cached and non-idempotent region rules.
- Returns attributes plus an access-fault flag, 2 cycles later, with full valid/ready backpressure.

---
 rtl/pma_check_pipe.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pma_check_pipe.sv
// ============================================================================
// Module      : pma_check_pipe
// Description : Two-stage physical-memory-attribute checker. Classifies each
//               request against execute / cached / non-idempotent regions and
//               returns attributes plus an access-fault flag two cycles later.
//               Optional response statistics: define CVA6_PMA_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pma_check_pipe #(
  parameter int unsigned PLEN           = 56,
  parameter int unsigned TagWidth       = 4,
  parameter int unsigned NrExecRules    = 3,
  parameter logic [NrExecRules*64-1:0] ExecBase =
      {64'h8000_0000, 64'h1_0000, 64'h0},
  parameter logic [NrExecRules*64-1:0] ExecLength =
      {64'h4000_0000, 64'h1_0000, 64'h1000},
  parameter int unsigned NrCachedRules  = 1,
  parameter logic [NrCachedRules*64-1:0] CachedBase   = 64'h8000_0000,
  parameter logic [NrCachedRules*64-1:0] CachedLength = 64'h4000_0000,
  parameter int unsigned NrNonIdemRules = 2,
  parameter logic [NrNonIdemRules*64-1:0] NonIdemBase   = {64'h0, 64'h0},
  parameter logic [NrNonIdemRules*64-1:0] NonIdemLength = {64'h0, 64'h0}
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [PLEN-1:0]     req_addr_i,
  input  logic [1:0]          req_type_i,
  input  logic [TagWidth-1:0] req_tag_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [TagWidth-1:0] rsp_tag_o,
  output logic                rsp_exec_o,
  output logic                rsp_cached_o,
  output logic                rsp_idem_o,
  output logic                rsp_fault_o,
  output logic [31:0]         stat_uncached_o,
  output logic [31:0]         stat_fault_o
);

  localparam logic [1:0] c_type_fetch = 2'd2;
  localparam logic [1:0] c_type_amo   = 2'd3;

  // Limit is formed in 65 bits so a region ending at 2^64 cannot wrap.
  function automatic logic rule_hit(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input logic [63:0] len);
    logic [64:0] lim;
    lim = {1'b0, base} + {1'b0, len};
    return (len != 64'd0) && (addr >= base) && ({1'b0, addr} < lim);
  endfunction

  logic [63:0]               w_addr64;
  logic [NrExecRules-1:0]    w_exec_hits;
  logic [NrCachedRules-1:0]  w_cached_hits;
  logic [NrNonIdemRules-1:0] w_nonidem_hits;

  assign w_addr64 = 64'(req_addr_i);

  for (genvar i = 0; i < NrExecRules; i++) begin : g_exec
    assign w_exec_hits[i] = rule_hit(w_addr64, ExecBase[i*64 +: 64],
                                     ExecLength[i*64 +: 64]);
  end

  for (genvar i = 0; i < NrCachedRules; i++) begin : g_cached
    assign w_cached_hits[i] = rule_hit(w_addr64, CachedBase[i*64 +: 64],
                                       CachedLength[i*64 +: 64]);
  end

  for (genvar i = 0; i < NrNonIdemRules; i++) begin : g_nonidem
    assign w_nonidem_hits[i] = rule_hit(w_addr64, NonIdemBase[i*64 +: 64],
                                        NonIdemLength[i*64 +: 64]);
  end

  // S1: registered request and raw hit vectors
  logic                      r_s1_valid;
  logic [TagWidth-1:0]       r_s1_tag;
  logic [1:0]                r_s1_type;
  logic [NrExecRules-1:0]    r_s1_exec_hits;
  logic [NrCachedRules-1:0]  r_s1_cached_hits;
  logic [NrNonIdemRules-1:0] r_s1_nonidem_hits;

  // S2: registered response
  logic                r_s2_valid;
  logic [TagWidth-1:0] r_s2_tag;
  logic                r_s2_exec;
  logic                r_s2_cached;
  logic                r_s2_idem;
  logic                r_s2_fault;

  logic w_s2_adv;
  logic w_s1_adv;
  logic w_exec;
  logic w_cached;
  logic w_fault;

  assign w_s2_adv = !r_s2_valid || rsp_ready_i;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;

  assign w_exec   = |r_s1_exec_hits;
  assign w_cached = |r_s1_cached_hits;
  assign w_fault  = ((r_s1_type == c_type_fetch) && !w_exec) ||
                    ((r_s1_type == c_type_amo)   && !w_cached);

  // A flush drains the pipe, so the input side is always open in that cycle.
  assign req_ready_o = w_s1_adv || flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid        <= 1'b0;
      r_s1_tag          <= '0;
      r_s1_type         <= '0;
      r_s1_exec_hits    <= '0;
      r_s1_cached_hits  <= '0;
      r_s1_nonidem_hits <= '0;
      r_s2_valid        <= 1'b0;
      r_s2_tag          <= '0;
      r_s2_exec         <= 1'b0;
      r_s2_cached       <= 1'b0;
      r_s2_idem         <= 1'b0;
      r_s2_fault        <= 1'b0;
    end else if (flush_i) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_tag    <= r_s1_tag;
          r_s2_exec   <= w_exec;
          r_s2_cached <= w_cached;
          r_s2_idem   <= ~|r_s1_nonidem_hits;
          r_s2_fault  <= w_fault;
        end
      end
      if (w_s1_adv) begin
        r_s1_valid <= req_valid_i;
        if (req_valid_i) begin
          r_s1_tag          <= req_tag_i;
          r_s1_type         <= req_type_i;
          r_s1_exec_hits    <= w_exec_hits;
          r_s1_cached_hits  <= w_cached_hits;
          r_s1_nonidem_hits <= w_nonidem_hits;
        end
      end
    end
  end

  assign rsp_valid_o  = r_s2_valid;
  assign rsp_tag_o    = r_s2_tag;
  assign rsp_exec_o   = r_s2_exec;
  assign rsp_cached_o = r_s2_cached;
  assign rsp_idem_o   = r_s2_idem;
  assign rsp_fault_o  = r_s2_fault;

`ifdef CVA6_PMA_STATS_EN
  logic [31:0] r_stat_uncached;
  logic [31:0] r_stat_fault;
  logic        w_rsp_hs;

  assign w_rsp_hs = r_s2_valid && rsp_ready_i;

  // Counters ignore flush: a response handed over in a flush cycle still counts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat_uncached <= '0;
      r_stat_fault    <= '0;
    end else if (w_rsp_hs) begin
      if (!r_s2_cached && (r_stat_uncached != 32'hFFFF_FFFF))
        r_stat_uncached <= r_stat_uncached + 32'd1;
      if (r_s2_fault && (r_stat_fault != 32'hFFFF_FFFF))
        r_stat_fault <= r_stat_fault + 32'd1;
    end
  end

  assign stat_uncached_o = r_stat_uncached;
  assign stat_fault_o    = r_stat_fault;
`else
  assign stat_uncached_o = 32'd0;
  assign stat_fault_o    = 32'd0;
`endif

endmodule

`default_nettype wire
